program_loader: RTL

- FSM that owns the shared 8-bit bus while the CPU is in programming mode and copies host-supplied bytes from ui_in into the 16-byte RAM.
- Uses a four-phase ready/valid handshake on uio pins, one byte per RAM address, starting at address 0.
- Sits beside control_block. While it is active, control_block holds all datapath enables inactive.
- When the load completes it raises done_load so control_block can start fetch at PC=0.

---
 rtl/program_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - host-driven RAM loader FSM with four-phase ready/valid handshake
module program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              programming,
    input  logic              host_valid,
    output logic              ready,
    output logic              done_load,
    output logic              busy,
    output logic              read_ui_in,
    output logic              addr_drive,
    output logic [ADDR_W-1:0] addr_out,
    output logic              n_load_addr,
    output logic              n_load_data,
    output logic              n_lr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VALID,
        S_LD_ADDR,
        S_LD_DATA,
        S_WRITE,
        S_WAIT_RELEASE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        prog_sync_q, valid_sync_q;
    logic              prog_s, valid_s;

    assign prog_s  = prog_sync_q[1];
    assign valid_s = valid_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            prog_sync_q  <= '0;
            valid_sync_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            prog_sync_q  <= {prog_sync_q[0], programming};
            valid_sync_q <= {valid_sync_q[0], host_valid};
        end
    end

    // Aborts let the strobe in flight finish; a byte already latched into MAR data is still written.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (prog_s) begin
                    state_d = S_WAIT_VALID;
                    addr_d  = '0;
                end
            end
            S_WAIT_VALID: begin
                if (!prog_s) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (valid_s) begin
                    state_d = S_LD_ADDR;
                end
            end
            S_LD_ADDR: begin
                if (prog_s) begin
                    state_d = S_LD_DATA;
                end else begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            end
            S_LD_DATA: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (prog_s) begin
                    state_d = S_WAIT_RELEASE;
                end else begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            end
            S_WAIT_RELEASE: begin
                if (!prog_s) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (!valid_s) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_VALID;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!prog_s) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Outputs decode the registered state only, so reset deasserts every strobe immediately.
    assign ready       = (state_q == S_WAIT_VALID);
    assign done_load   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign addr_drive  = (state_q == S_LD_ADDR);
    assign read_ui_in  = (state_q == S_LD_DATA);
    assign n_load_addr = (state_q != S_LD_ADDR);
    assign n_load_data = (state_q != S_LD_DATA);
    assign n_lr        = (state_q != S_WRITE);
    assign addr_out    = addr_q;

endmodule
